// File: rtl/stable_chk_if.sv
// ---------------------------------------------------------------------------
// stable_chk_if
// Bundles the monitored bus and the status outputs of the stability checker.
//   master modport : the side that drives en/clr/qual/data and reads status
//   slave  modport : the checker itself (reads the bus, drives status)
// Signals:
//   en         check enable
//   clr        synchronous clear of sticky/count/capture state
//   qual       per-channel qualifier
//   data       packed channel data, channel i at [i*DATA_W +: DATA_W]
//   pass_pulse one-cycle pass indication per channel
//   err_pulse  one-cycle violation indication per channel
//   err_sticky latched violation flag per channel
//   err_cnt    saturating total violation count
//   first_vld  a first violation has been captured
//   first_ch   lowest-index channel of the first violating edge
// CH_W must be set to max(1, $clog2(NUM_CH)) by the instantiating code.
// ---------------------------------------------------------------------------
interface stable_chk_if #(
    parameter int NUM_CH = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 8,
    parameter int CH_W   = 2
);
    logic                     en;
    logic                     clr;
    logic [NUM_CH-1:0]        qual;
    logic [NUM_CH*DATA_W-1:0] data;
    logic [NUM_CH-1:0]        pass_pulse;
    logic [NUM_CH-1:0]        err_pulse;
    logic [NUM_CH-1:0]        err_sticky;
    logic [CNT_W-1:0]         err_cnt;
    logic                     first_vld;
    logic [CH_W-1:0]          first_ch;

    modport master (
        output en, clr, qual, data,
        input  pass_pulse, err_pulse, err_sticky, err_cnt, first_vld, first_ch
    );

    modport slave (
        input  en, clr, qual, data,
        output pass_pulse, err_pulse, err_sticky, err_cnt, first_vld, first_ch
    );
endinterface

// File: rtl/stable_chk.sv
// ---------------------------------------------------------------------------
// stable_chk
// Per-channel data stability monitor. Whenever a channel's qualifier is high
// at a clock edge (and checking is enabled and warmed up), that channel's data
// must have been unchanged for the last STABLE_CYC edges. Produces pass/error
// pulses, sticky error flags, a saturating error counter and a capture of the
// lowest channel of the first violating edge.
// Ports:
//   clk    clock, everything on posedge
//   rst_n  synchronous active-low reset
//   bus    stable_chk_if.slave (en, clr, qual, data in; status out)
// Optional feature: define STABLE_CHK_SVA_EN to compile simulation-only
// concurrent assertions that mirror the check per channel; outputs are the
// same with or without it.
// ---------------------------------------------------------------------------
module stable_chk #(
    parameter int NUM_CH     = 4,
    parameter int DATA_W     = 8,
    parameter int STABLE_CYC = 1,
    parameter int CNT_W      = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    stable_chk_if.slave bus
);
    localparam int CH_W  = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int RUN_W = $clog2(STABLE_CYC + 1);
    localparam int PC_W  = $clog2(NUM_CH + 1);
    localparam int SUM_W = CNT_W + PC_W;
    localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE_CYC);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic [DATA_W-1:0] chData [NUM_CH];
    logic [DATA_W-1:0] hist_q [NUM_CH];
    logic [RUN_W-1:0]  run_q  [NUM_CH];
    logic [RUN_W-1:0]  run_d  [NUM_CH];
    logic [RUN_W-1:0]  wcnt_q, wcnt_d;
    logic              armed;
    logic [NUM_CH-1:0] viol, pass;
    logic [PC_W-1:0]   violCnt;
    logic [CH_W-1:0]   firstIdx;
    logic [SUM_W-1:0]  cntSum;

    logic [NUM_CH-1:0] pass_pulse_q, err_pulse_q;
    logic [NUM_CH-1:0] err_sticky_q, err_sticky_d;
    logic [CNT_W-1:0]  err_cnt_q, err_cnt_d;
    logic              first_vld_q, first_vld_d;
    logic [CH_W-1:0]   first_ch_q, first_ch_d;

    // Per-channel evaluation. The run length counts consecutive edges at which
    // the data matched the previous edge, saturating at STABLE_CYC, so a check
    // passes only when every one of the last STABLE_CYC edges saw no change.
    // Warm-up holds checks off until the history covers STABLE_CYC edges after
    // reset release, because the reset value of hist is not real data.
    always_comb begin
        chData   = '{default: '0};
        run_d    = '{default: '0};
        viol     = '0;
        pass     = '0;
        violCnt  = '0;
        firstIdx = '0;
        armed    = (wcnt_q == RUN_MAX);
        wcnt_d   = armed ? wcnt_q : wcnt_q + RUN_W'(1);
        for (int i = 0; i < NUM_CH; i++) begin
            chData[i] = bus.data[i*DATA_W +: DATA_W];
            if (chData[i] != hist_q[i]) begin
                run_d[i] = '0;
            end else if (run_q[i] == RUN_MAX) begin
                run_d[i] = RUN_MAX;
            end else begin
                run_d[i] = run_q[i] + RUN_W'(1);
            end
            viol[i] = bus.en & armed & bus.qual[i] & (run_d[i] < RUN_MAX);
            pass[i] = bus.en & armed & bus.qual[i] & (run_d[i] == RUN_MAX);
            violCnt = violCnt + PC_W'(viol[i]);
        end
        for (int i = NUM_CH - 1; i >= 0; i--) begin
            if (viol[i]) begin
                firstIdx = CH_W'(i);
            end
        end
    end

    // Status update. The count is summed in a wider accumulator so that
    // several simultaneous violations clamp at the maximum instead of
    // wrapping. Clear overrides any violation on the same edge for the
    // latched state; the pulses are handled separately and still fire.
    always_comb begin
        err_sticky_d = err_sticky_q | viol;
        cntSum       = SUM_W'(err_cnt_q) + SUM_W'(violCnt);
        err_cnt_d    = (cntSum > SUM_W'(CNT_MAX)) ? CNT_MAX : cntSum[CNT_W-1:0];
        first_vld_d  = first_vld_q;
        first_ch_d   = first_ch_q;
        if (!first_vld_q && (|viol)) begin
            first_vld_d = 1'b1;
            first_ch_d  = firstIdx;
        end
        if (bus.clr) begin
            err_sticky_d = '0;
            err_cnt_d    = '0;
            first_vld_d  = 1'b0;
            first_ch_d   = '0;
        end
    end

    // State registers. History, run lengths and warm-up keep tracking while
    // checking is disabled, so re-enabling needs no fresh warm-up.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_CH; i++) begin
                hist_q[i] <= '0;
                run_q[i]  <= '0;
            end
            wcnt_q       <= '0;
            pass_pulse_q <= '0;
            err_pulse_q  <= '0;
            err_sticky_q <= '0;
            err_cnt_q    <= '0;
            first_vld_q  <= 1'b0;
            first_ch_q   <= '0;
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                hist_q[i] <= chData[i];
                run_q[i]  <= run_d[i];
            end
            wcnt_q       <= wcnt_d;
            pass_pulse_q <= pass;
            err_pulse_q  <= viol;
            err_sticky_q <= err_sticky_d;
            err_cnt_q    <= err_cnt_d;
            first_vld_q  <= first_vld_d;
            first_ch_q   <= first_ch_d;
        end
    end

    assign bus.pass_pulse = pass_pulse_q;
    assign bus.err_pulse  = err_pulse_q;
    assign bus.err_sticky = err_sticky_q;
    assign bus.err_cnt    = err_cnt_q;
    assign bus.first_vld  = first_vld_q;
    assign bus.first_ch   = first_ch_q;

`ifdef STABLE_CHK_SVA_EN
    // Independent formulation of the same rule: a qualified, armed edge
    // requires the data to equal its value at each of the previous
    // STABLE_CYC edges.
    for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_sva_ch
        for (genvar gk = 1; gk <= STABLE_CYC; gk++) begin : g_sva_lag
            a_stable: assert property (@(posedge clk) disable iff (!rst_n)
                (bus.en && armed && bus.qual[gi]) |->
                (bus.data[gi*DATA_W +: DATA_W] == $past(bus.data[gi*DATA_W +: DATA_W], gk)))
                else $error("stable_chk: channel %0d data changed within last %0d edges at %0t",
                            gi, gk, $time);
        end
    end
`endif
endmodule

// File: tb/tb_stable_chk.sv
// ---------------------------------------------------------------------------
// tb_stable_chk
// Directed bench for stable_chk. Two instances share clock and reset:
//   dutA : NUM_CH=4, DATA_W=8, STABLE_CYC=1, CNT_W=2 (multi-channel, clr,
//          saturation, enable and reset behaviour)
//   dutB : NUM_CH=1, DATA_W=8, STABLE_CYC=3, CNT_W=8 (multi-edge stability
//          and warm-up)
// ---------------------------------------------------------------------------
module tb_stable_chk;
    logic clk = 1'b0;
    logic rst_n;
    int   checkCount = 0;
    int   failCount  = 0;
    logic [7:0] aData [4];
    logic [7:0] bData;

    // Free-running clock, period 10, rising edges at 5, 15, 25, ...
    always #5 clk = ~clk;

    stable_chk_if #(.NUM_CH(4), .DATA_W(8), .CNT_W(2), .CH_W(2)) busA ();
    stable_chk_if #(.NUM_CH(1), .DATA_W(8), .CNT_W(8), .CH_W(1)) busB ();

    stable_chk #(.NUM_CH(4), .DATA_W(8), .STABLE_CYC(1), .CNT_W(2)) dutA (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busA.slave)
    );

    stable_chk #(.NUM_CH(1), .DATA_W(8), .STABLE_CYC(3), .CNT_W(8)) dutB (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (busB.slave)
    );

    // Single comparison point: counts and reports every check.
    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Compares every status output of dutA against hand-computed values.
    task automatic checkA(input string tag, input logic [31:0] expErr, input logic [31:0] expPass,
                          input logic [31:0] expSticky, input logic [31:0] expCnt,
                          input logic [31:0] expFv, input logic [31:0] expFch);
        checkOutput({tag, " A.err_pulse"},  32'(busA.err_pulse),  expErr);
        checkOutput({tag, " A.pass_pulse"}, 32'(busA.pass_pulse), expPass);
        checkOutput({tag, " A.err_sticky"}, 32'(busA.err_sticky), expSticky);
        checkOutput({tag, " A.err_cnt"},    32'(busA.err_cnt),    expCnt);
        checkOutput({tag, " A.first_vld"},  32'(busA.first_vld),  expFv);
        checkOutput({tag, " A.first_ch"},   32'(busA.first_ch),   expFch);
    endtask

    // Drives both buses, then advances one rising edge and settles 1 time unit.
    task automatic applyStimulus(input logic aEn, input logic aClr, input logic [3:0] aQual,
                                 input logic bQual);
        busA.en   = aEn;
        busA.clr  = aClr;
        busA.qual = aQual;
        busA.data = {aData[3], aData[2], aData[1], aData[0]};
        busB.en   = 1'b1;
        busB.clr  = 1'b0;
        busB.qual = bQual;
        busB.data = bData;
        @(posedge clk);
        #1;
    endtask

    // Guards against a hung run.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        for (int i = 0; i < 4; i++) aData[i] = 8'h00;
        bData = 8'h00;
        for (int i = 0; i < 3; i++) applyStimulus(1'b0, 1'b0, 4'h0, 1'b1);
        checkA("reset", 'h0, 'h0, 'h0, 'h0, 'h0, 'h0);
        checkOutput("reset B.pass_pulse", 32'(busB.pass_pulse), 'h0);

        rst_n = 1'b1;
        applyStimulus(1'b1, 1'b0, 4'hF, 1'b1);
        checkA("E1 unchecked", 'h0, 'h0, 'h0, 'h0, 'h0, 'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 1'b1);
        checkA("E2 pass", 'h0, 'hF, 'h0, 'h0, 'h0, 'h0);

        aData[0] = 8'h01;
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        checkA("E3 vacuous", 'h0, 'h0, 'h0, 'h0, 'h0, 'h0);
        aData[0] = 8'h00;
        applyStimulus(1'b1, 1'b0, 4'h1, 1'b1);
        checkA("E4 toggle", 'h1, 'h0, 'h1, 'h1, 'h1, 'h0);

        aData[3] = 8'h11;
        applyStimulus(1'b1, 1'b1, 4'h8, 1'b1);
        checkA("E5 clr wins", 'h8, 'h0, 'h0, 'h0, 'h0, 'h0);

        aData[1] = 8'h22;
        aData[2] = 8'h33;
        applyStimulus(1'b1, 1'b0, 4'hE, 1'b1);
        checkA("E6 dual", 'h6, 'h8, 'h6, 'h2, 'h1, 'h1);

        aData[0] = 8'h44;
        applyStimulus(1'b1, 1'b0, 4'h1, 1'b1);
        checkA("E7 ch0", 'h1, 'h0, 'h7, 'h3, 'h1, 'h1);
        aData[0] = 8'h45;
        applyStimulus(1'b1, 1'b0, 4'h1, 1'b1);
        checkA("E8 sat", 'h1, 'h0, 'h7, 'h3, 'h1, 'h1);

        aData[0] = 8'h46;
        aData[1] = 8'h23;
        aData[2] = 8'h34;
        aData[3] = 8'h12;
        applyStimulus(1'b1, 1'b0, 4'hF, 1'b1);
        checkA("E9 all", 'hF, 'h0, 'hF, 'h3, 'h1, 'h1);

        applyStimulus(1'b1, 1'b1, 4'h0, 1'b1);
        checkA("E10 clr", 'h0, 'h0, 'h0, 'h0, 'h0, 'h0);

        aData[0] = 8'h47;
        aData[1] = 8'h24;
        aData[2] = 8'h35;
        aData[3] = 8'h13;
        applyStimulus(1'b0, 1'b0, 4'hF, 1'b1);
        checkA("E11 en off", 'h0, 'h0, 'h0, 'h0, 'h0, 'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 1'b1);
        checkA("E12 reenable", 'h0, 'hF, 'h0, 'h0, 'h0, 'h0);

        aData[2] = 8'h36;
        applyStimulus(1'b1, 1'b0, 4'h4, 1'b1);
        checkA("E13 ch2", 'h4, 'h0, 'h4, 'h1, 'h1, 'h2);
        checkOutput("E13 B.pass_pulse", 32'(busB.pass_pulse), 'h1);

        rst_n = 1'b0;
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        checkA("E14 reset", 'h0, 'h0, 'h0, 'h0, 'h0, 'h0);
        checkOutput("E14 B.pass_pulse", 32'(busB.pass_pulse), 'h0);

        rst_n = 1'b1;
        aData[0] = 8'h48;
        applyStimulus(1'b1, 1'b0, 4'hF, 1'b1);
        checkA("E15 first edge", 'h0, 'h0, 'h0, 'h0, 'h0, 'h0);
        checkOutput("E15 B.pass_pulse", 32'(busB.pass_pulse), 'h0);
        applyStimulus(1'b1, 1'b0, 4'hF, 1'b1);
        checkA("E16 armed", 'h0, 'hF, 'h0, 'h0, 'h0, 'h0);
        checkOutput("E16 B.pass_pulse", 32'(busB.pass_pulse), 'h0);

        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        checkOutput("E17 B.pass_pulse", 32'(busB.pass_pulse), 'h0);
        checkOutput("E17 B.err_pulse",  32'(busB.err_pulse),  'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        checkOutput("E18 B.pass_pulse", 32'(busB.pass_pulse), 'h1);

        bData = 8'hA5;
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
        checkOutput("E19 B.pass_pulse", 32'(busB.pass_pulse), 'h0);
        checkOutput("E19 B.err_pulse",  32'(busB.err_pulse),  'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        checkOutput("E21 B.err_pulse",  32'(busB.err_pulse),  'h1);
        checkOutput("E21 B.pass_pulse", 32'(busB.pass_pulse), 'h0);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        checkOutput("E22 B.pass_pulse", 32'(busB.pass_pulse), 'h1);
        checkOutput("E22 B.err_pulse",  32'(busB.err_pulse),  'h0);

        bData = 8'h5A;
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b0);
        applyStimulus(1'b1, 1'b0, 4'h0, 1'b1);
        checkOutput("E25 B.err_pulse",  32'(busB.err_pulse),  'h1);
        checkOutput("E25 B.err_cnt",    32'(busB.err_cnt),    'h2);
        checkOutput("E25 B.err_sticky", 32'(busB.err_sticky), 'h1);
        checkOutput("E25 B.first_vld",  32'(busB.first_vld),  'h1);
        checkOutput("E25 B.first_ch",   32'(busB.first_ch),   'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", checkCount, failCount);
        $finish;
    end
endmodule

// File: doc/stable_chk.md
# stable_chk

Synthesizable, parametrised stability checker: for each of NUM_CH channels, whenever the qualifier is high at a clock edge, the channel's DATA_W-bit data must have stayed unchanged for the last STABLE_CYC edges. It generalises the single-bit `a |-> $stable(b)` check into hardware, with per-channel pass/fail pulses, sticky flags, a saturating violation counter and first-failure capture. It sits beside datapaths and interfaces as an on-chip monitor readable by status logic.

## Interface
- NUM_CH, 4, number of monitored channels (≥1)
- DATA_W, 8, data width per channel (≥1)
- STABLE_CYC, 1, consecutive unchanged edges required (≥1; 1 = `$stable` semantics)
- CNT_W, 8, violation counter width
- CH_W, derived, max(1, $clog2(NUM_CH))

- clk  in  1  clock, all logic on posedge
- rst_n  in  1  synchronous, active-low reset
- en  in  1  check enable; history tracking continues when low
- clr  in  1  synchronous clear of sticky/count/capture state
- qual  in  NUM_CH  per-channel qualifier (antecedent)
- data  in  NUM_CH*DATA_W  channel i at bits [i*DATA_W +: DATA_W]
- pass_pulse  out  NUM_CH  one-cycle pass indication per channel
- err_pulse  out  NUM_CH  one-cycle violation indication per channel
- err_sticky  out  NUM_CH  latched violation flag per channel
- err_cnt  out  CNT_W  saturating total violation count
- first_vld  out  1  a first violation has been captured
- first_ch  out  CH_W  lowest-index channel of the first violating edge

## Operation
- Per channel: hist register (data at previous edge), run counter (consecutive unchanged edges, saturates at STABLE_CYC).
- Global warm-up counter wcnt, increments each edge with rst_n high, saturates at STABLE_CYC; armed = (wcnt == STABLE_CYC).
- At each edge, per channel i: same = (data_i == hist_i); run_next = same ? sat(run+1) : 0; hist ← data_i; run ← run_next.
- chk_i = en & armed & qual[i]; viol_i = chk_i & (run_next < STABLE_CYC); pass_i = chk_i & ~viol_i.
- err_pulse[i] ← viol_i; pass_pulse[i] ← pass_i.
- err_sticky[i] set by viol_i, held until clr or reset.
- err_cnt ← sat(err_cnt + popcount(viol)); saturates at 2^CNT_W−1, never wraps.
- First capture: if ~first_vld and any viol_i, first_vld ← 1, first_ch ← lowest i with viol_i; later violations do not overwrite.
- clr: clears err_sticky, err_cnt, first_vld, first_ch; hist/run/wcnt unaffected. Violations on a clr edge: clr wins for sticky/count/capture, err_pulse still reflects them.
- en low: no pass/err pulses, no sticky/count update; hist and run keep tracking, so re-enabling needs no warm-up.
- qual low: channel unchecked (vacuous), no pulse.

## Timing
- Reset (rst_n low at edge): all outputs 0; hist 0, run 0, wcnt 0.
- Latency: violation sampled at edge k → err_pulse/pass_pulse high for the cycle after edge k; sticky, err_cnt, first_* update at edge k.
- First edge after reset release is never checked (hist invalid); earliest check is edge STABLE_CYC+1 after release.
- Reset mid-operation clears all state including warm-up; re-warm required.
- Multiple channels violating on one edge: count adds all; first_ch takes lowest index.

## Configuration
- STABLE_CHK_SVA_EN defined: per channel, a simulation-only concurrent assertion checks `disable iff (!rst_n)` en & armed & qual[i] |-> data_i unchanged over STABLE_CYC edges, reporting $error with channel and time. Undefined: no assertions compiled; RTL outputs identical either way.

## Test plan
- NUM_CH=1, DATA_W=1, STABLE_CYC=1, clk period 10, rst_n released before edge 5; data toggles 0→1→0 at 35/45 with qual=1 at 45 → err_pulse after edge 45, err_cnt=1, first_ch=0.
- STABLE_CYC=3, data held 0xA5 for 3 edges then qual=1 → pass_pulse; change to 0x5A then qual=1 two edges later → err_pulse.
- NUM_CH=4: channels 2 and 1 violate on the same edge → err_cnt+=2, first_ch=1, err_sticky=4'b0110; later ch0 violation leaves first_ch=1.
- CNT_W=2: five violations → err_cnt stays 3; clr → err_cnt=0, err_sticky=0, first_vld=0 next cycle.
- en=0 with qual=1 and changing data → no pulses, no count; en=1 next edge with data stable → pass_pulse without warm-up.
- Reset asserted mid-stream with err_sticky set → all outputs 0; qual=1 on first edge after release → no pulse.
